// File: rtl/button_event.sv
// Classifies a debounced button into press / short / long / auto-repeat / release pulses.
// state        | meaning
// WAIT_RELEASE | after reset; ignore the button until it is seen released
// IDLE         | released, waiting for a press
// PRESSED      | held, counting towards the long-press threshold
// LONG_HELD    | held past the threshold, counting repeat periods
module button_event #(
    parameter int CLK_FREQ  = 50000000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_level,
    output logic press,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int LONG_CYCLES   = CLK_FREQ / 1000 * LONG_MS;
    localparam int REPEAT_CYCLES = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int CNT_MAX       = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW            = $clog2(CNT_MAX + 1);
    localparam bit REP_EN        = (REPEAT_CYCLES > 0);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    generate
        if (LONG_CYCLES < 2 || (REPEAT_CYCLES > 0 && REPEAT_CYCLES < 2)) begin : g_param_check
            $error("button_event: LONG_CYCLES must be >= 2 and REPEAT_CYCLES 0 or >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          rel_q, rel_d;
    logic          held_q, held_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            WAIT_RELEASE: begin
                if (!btn_level) state_d = IDLE;
            end
            IDLE: begin
                if (btn_level) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // a release seen on the threshold edge still counts as short
                if (!btn_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                    rel_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (REP_EN) begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase

        held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    assign press         = press_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = rep_q;
    assign release_pulse = rel_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: 20-cycle long threshold, 5-cycle repeat, and a no-repeat instance.
module tb_button_event;

    logic clk = 1'b0;
    logic rst_n;
    logic btn, btn2;

    logic p1, s1, l1, r1, rl1, h1;
    logic p2, s2, l2, r2, rl2, h2;
    logic [5:0] obs, obs2;

    int n_checks = 0;
    int n_errors = 0;
    int n_long2  = 0;
    int n_rep2   = 0;

    always #5 clk = ~clk;

    button_event #(.CLK_FREQ(1000), .LONG_MS(20), .REPEAT_MS(5)) dut (
        .clk(clk), .reset_n(rst_n), .btn_level(btn),
        .press(p1), .short_press(s1), .long_press(l1),
        .repeat_pulse(r1), .release_pulse(rl1), .held(h1)
    );

    button_event #(.CLK_FREQ(1000), .LONG_MS(20), .REPEAT_MS(0)) dut_norep (
        .clk(clk), .reset_n(rst_n), .btn_level(btn2),
        .press(p2), .short_press(s2), .long_press(l2),
        .repeat_pulse(r2), .release_pulse(rl2), .held(h2)
    );

    // {press, short_press, long_press, repeat_pulse, release_pulse, held}
    assign obs  = {p1, s1, l1, r1, rl1, h1};
    assign obs2 = {p2, s2, l2, r2, rl2, h2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] e;
        btn   = 1'b0;
        btn2  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'(obs), 32'h0);
        chk("reset_state_norep", 32'(obs2), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_after_reset", 32'(obs), 32'h0);

        // short press of 10 cycles
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            e = {i == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            chk($sformatf("short_hold[%0d]", i), 32'(obs), 32'(e));
        end
        btn = 1'b0;
        step();
        chk("short_release", 32'(obs), 32'(6'b010010));
        step();
        chk("short_after", 32'(obs), 32'h0);

        // long hold of 32 cycles with auto-repeat
        btn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            e = {i == 0, 1'b0, i == 20, (i == 25) || (i == 30), 1'b0, 1'b1};
            chk($sformatf("long_hold[%0d]", i), 32'(obs), 32'(e));
        end
        btn = 1'b0;
        step();
        chk("long_release", 32'(obs), 32'(6'b000010));
        step();
        chk("long_after", 32'(obs), 32'h0);

        // release sampled exactly on the threshold edge
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            e = {i == 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            chk($sformatf("edge_hold[%0d]", i), 32'(obs), 32'(e));
        end
        btn = 1'b0;
        step();
        chk("edge_release", 32'(obs), 32'(6'b010010));
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("edge_after[%0d]", i), 32'(obs), 32'h0);
        end

        // button held across reset deassertion
        btn   = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("held_reset_async", 32'(obs), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("held_thru_reset[%0d]", i), 32'(obs), 32'h0);
        end
        btn = 1'b0;
        step();
        chk("held_thru_release", 32'(obs), 32'h0);
        btn = 1'b1;
        step();
        chk("repress_press", 32'(obs), 32'(6'b100001));
        btn = 1'b0;
        step();
        chk("repress_release", 32'(obs), 32'(6'b010010));
        step();

        // reset pulsed in the middle of LONG_HELD
        btn = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            e = {i == 0, 1'b0, i == 20, 1'b0, 1'b0, 1'b1};
            chk($sformatf("mid_hold[%0d]", i), 32'(obs), 32'(e));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_async", 32'(obs), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("mid_after_reset[%0d]", i), 32'(obs), 32'h0);
        end
        btn = 1'b0;
        step();
        chk("mid_release", 32'(obs), 32'h0);
        step();
        chk("mid_idle", 32'(obs), 32'h0);

        // repeat disabled: single long_press, no repeats
        btn2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (l2) n_long2++;
            if (r2) n_rep2++;
            e = {i == 0, 1'b0, i == 20, 1'b0, 1'b0, 1'b1};
            chk($sformatf("norep_hold[%0d]", i), 32'(obs2), 32'(e));
        end
        chk("norep_long_count", 32'(n_long2), 32'd1);
        chk("norep_repeat_count", 32'(n_rep2), 32'd0);
        btn2 = 1'b0;
        step();
        chk("norep_release", 32'(obs2), 32'(6'b000010));
        step();
        chk("norep_after", 32'(obs2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter LONG_MS, default 1000, hold time in ms for a long press.
REQ-003 Parameter REPEAT_MS, default 200, auto-repeat period in ms while long-held; 0 disables repeat.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_level  input  1  debounced button level from the upstream debounce stage, already synchronous to clk.
REQ-007 press  output  1  one-cycle pulse on each accepted press.
REQ-008 short_press  output  1  one-cycle pulse on release before the long threshold.
REQ-009 long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-010 repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
REQ-011 release  output  1  one-cycle pulse on every release of an accepted press.
REQ-012 held  output  1  high while in PRESSED or LONG_HELD.

Function
REQ-013 LONG_CYCLES = CLK_FREQ/1000*LONG_MS and REPEAT_CYCLES = CLK_FREQ/1000*REPEAT_MS; integer arithmetic at elaboration.
REQ-014 LONG_CYCLES < 2, or 0 < REPEAT_CYCLES < 2, is an elaboration error.
REQ-015 Cycle counter width = $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1); the counter never wraps.
REQ-016 All outputs are registered; no combinational path from btn_level to any output.
REQ-017 States: WAIT_RELEASE, IDLE, PRESSED, LONG_HELD.
REQ-018 WAIT_RELEASE: stays while btn_level=1; goes to IDLE on the first edge sampling btn_level=0; no pulses.
REQ-019 IDLE, edge E sampling btn_level=1: go to PRESSED, cnt<=0, press<=1.
REQ-020 PRESSED, btn_level=1, cnt/=LONG_CYCLES-1: cnt increments.
REQ-021 PRESSED, btn_level=1, cnt=LONG_CYCLES-1: go to LONG_HELD, cnt<=0, long_press<=1; long_press is therefore high in the cycle after edge E+LONG_CYCLES.
REQ-022 PRESSED, btn_level=0: go to IDLE, short_press<=1, release<=1.
REQ-023 Release sampled at the threshold edge has priority: short_press and release fire, no long_press.
REQ-024 LONG_HELD, btn_level=1, REPEAT_CYCLES>0: cnt increments; at cnt=REPEAT_CYCLES-1, repeat_pulse<=1 and cnt<=0.
REQ-025 Repeat pulses follow edges E+LONG_CYCLES+k*REPEAT_CYCLES, k>=1.
REQ-026 LONG_HELD with REPEAT_CYCLES=0: cnt holds; repeat_pulse never asserts.
REQ-027 LONG_HELD, btn_level=0: go to IDLE, release<=1; no short_press; any due repeat_pulse is suppressed.
REQ-028 Each pulse output is high for exactly one cycle.
REQ-029 press and short_press are never high in the same cycle; long_press and repeat_pulse are never high in the same cycle.
REQ-030 held is registered and equals 1 in the cycles after the edges that enter PRESSED or LONG_HELD.

Reset
REQ-031 reset_n=0 immediately (asynchronously) forces every output to 0, state to WAIT_RELEASE and cnt to 0.
REQ-032 A button held through reset generates no press until released and pressed again; the same applies to reset asserted mid-press.

Verification
REQ-033 Bench params CLK_FREQ=1000, LONG_MS=20, REPEAT_MS=5 (LONG_CYCLES=20, REPEAT_CYCLES=5); the bench shall cover the directed scenarios in REQ-034 to REQ-039.
REQ-034 Reset with btn=0, press 10 cycles, release -> press 1 cycle after E; short_press+release 1 cycle after the release edge; no long_press.
REQ-035 Hold 32 cycles -> long_press after E+20; repeat_pulse after E+25 and E+30; release pulse only on release; held=1 throughout.
REQ-036 Release sampled exactly at edge E+20 -> short_press+release, no long_press, no repeat_pulse.
REQ-037 btn=1 across reset deassertion, held 50 cycles -> all outputs 0; then release and re-press -> normal press pulse.
REQ-038 reset_n pulsed low mid-LONG_HELD -> outputs 0 within the reset cycle without a clock edge; no release pulse; btn still high -> no press.
REQ-039 REPEAT_MS=0, hold 60 cycles -> single long_press after E+20, zero repeat_pulse.
